// File: rtl/plic_lite.sv
// Lightweight platform-level interrupt controller: per-source synchronisers and
// level/edge gateways, priority/threshold arbitration, and a claim/complete handshake.
module plic_lite #(
  parameter int          NUM_SRC    = 8,
  parameter int          PRIO_WIDTH = 3,
  parameter logic [30:0] EDGE_MASK  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_SRC-1:0]    src_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [7:0]            addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o,
  output logic                  irq_o
);

  logic [NUM_SRC-1:0]    sync1_q, sync2_q, prev_q;
  logic [NUM_SRC-1:0]    pend_q, pend_d, ins_q, ins_d, held_q, held_d;
  logic [NUM_SRC-1:0]    en_q;
  logic [PRIO_WIDTH-1:0] prio_q [NUM_SRC];
  logic [PRIO_WIDTH-1:0] thr_q, best_p;
  logic [4:0]            best_q, best_d;
  logic                  irq_q;
  logic [5:0]            word;
  logic                  claim, complete;
  logic [NUM_SRC-1:0]    rise;
  logic                  unused_ok;

  assign word      = addr_i[7:2];
  assign claim     = req_i && !we_i && (word == 6'h23);
  assign complete  = req_i && we_i && (word == 6'h23);
  assign rise      = sync2_q & ~prev_q;
  assign irq_o     = irq_q;
  assign unused_ok = ^{addr_i[1:0], wdata_i};

  // Gateways: the claimed source becomes in-service even if it sees a new edge
  // in the same cycle; that edge is parked in edge_held.
  always_comb begin
    pend_d = pend_q;
    ins_d  = ins_q;
    held_d = held_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (claim && best_q == 5'(i + 1)) begin
        pend_d[i] = 1'b0;
        ins_d[i]  = 1'b1;
        if (EDGE_MASK[i] && rise[i]) held_d[i] = 1'b1;
      end else if (complete && wdata_i[4:0] == 5'(i + 1) && ins_q[i]) begin
        ins_d[i] = 1'b0;
        if (EDGE_MASK[i]) begin
          if (held_q[i] || rise[i]) pend_d[i] = 1'b1;
          held_d[i] = 1'b0;
        end
      end else if (EDGE_MASK[i]) begin
        if (rise[i] && !pend_q[i] && !ins_q[i]) pend_d[i] = 1'b1;
        else if (rise[i] && ins_q[i])          held_d[i] = 1'b1;
      end else if (sync2_q[i] && !pend_q[i] && !ins_q[i]) begin
        pend_d[i] = 1'b1;
      end
    end
  end

  // Starting the running maximum at the threshold folds the eligibility compare
  // into the search; strict '>' keeps ties on the lowest ID.
  always_comb begin
    best_d = '0;
    best_p = thr_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pend_q[i] && en_q[i] && !(claim && best_q == 5'(i + 1)) && prio_q[i] > best_p) begin
        best_d = 5'(i + 1);
        best_p = prio_q[i];
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    case (word)
      6'h20: rdata_o[NUM_SRC:1] = pend_q;
      6'h21: rdata_o[NUM_SRC:1] = en_q;
      6'h22: rdata_o[PRIO_WIDTH-1:0] = thr_q;
      6'h23: rdata_o[4:0] = best_q;
      default: begin
        for (int i = 0; i < NUM_SRC; i++)
          if (word == 6'(i + 1)) rdata_o[PRIO_WIDTH-1:0] = prio_q[i];
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      ins_q   <= '0;
      held_q  <= '0;
      en_q    <= '0;
      thr_q   <= '0;
      best_q  <= '0;
      irq_q   <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) prio_q[i] <= '0;
    end else begin
      sync1_q <= src_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pend_q  <= pend_d;
      ins_q   <= ins_d;
      held_q  <= held_d;
      best_q  <= best_d;
      irq_q   <= (best_d != 5'd0);
      if (req_i && we_i) begin
        case (word)
          6'h21: en_q  <= wdata_i[NUM_SRC:1];
          6'h22: thr_q <= wdata_i[PRIO_WIDTH-1:0];
          default: begin
            for (int i = 0; i < NUM_SRC; i++)
              if (word == 6'(i + 1)) prio_q[i] <= wdata_i[PRIO_WIDTH-1:0];
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_plic_lite.sv
// Directed bench for plic_lite (8 sources, source 5 edge-triggered).
module tb_plic_lite;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  src;
  logic        req, we;
  logic [7:0]  addr;
  logic [31:0] wdata, rdata;
  logic        irq;
  int          n_checks = 0;
  int          n_fail   = 0;

  plic_lite #(.NUM_SRC(8), .PRIO_WIDTH(3), .EDGE_MASK(31'h10)) dut (
    .clk_i(clk), .rst_i(rst), .src_i(src), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a;
    #1 d = rdata;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_rd(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    n_checks++;
    if (d !== exp) begin
      n_fail++;
      $display("FAIL %s: addr 0x%02h read 0x%08h, expected 0x%08h", name, a, d, exp);
    end
  endtask

  task automatic chk_irq(input string name, input logic exp);
    n_checks++;
    if (irq !== exp) begin
      n_fail++;
      $display("FAIL %s: irq_o=%b, expected %b", name, irq, exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; src = '0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    cycles(3);
    chk_irq("reset_irq", 1'b0);
    @(negedge clk); rst = 1'b0;
    for (int a = 0; a < 256; a += 4) chk_rd("reset_read", 8'(a), 32'h0);
  endtask

  task automatic test_regs;
    bus_wr(8'h0C, 32'hFFFF_FFFF);
    chk_rd("prio_mask", 8'h0C, 32'h7);
    bus_wr(8'h84, 32'hFFFF_FFFF);
    chk_rd("enable_mask", 8'h84, 32'h1FE);
    bus_wr(8'h88, 32'h0000_000D);
    chk_rd("thr_mask", 8'h88, 32'h5);
    bus_wr(8'hC0, 32'h1234_5678);
    chk_rd("unmapped", 8'hC0, 32'h0);
    bus_wr(8'h00, 32'h7);
    chk_rd("prio0", 8'h00, 32'h0);
    bus_wr(8'h84, 32'h0);
    bus_wr(8'h88, 32'h0);
  endtask

  task automatic test_level;
    bus_wr(8'h0C, 32'd2);
    bus_wr(8'h84, 32'h08);
    src[2] = 1'b1;
    cycles(3);
    chk_irq("level_before_e4", 1'b0);
    cycles(1);
    chk_irq("level_after_e4", 1'b1);
    chk_rd("level_pending", 8'h80, 32'h08);
    chk_rd("level_claim", 8'h8C, 32'd3);
    chk_irq("level_post_claim", 1'b0);
    chk_rd("level_pending_cleared", 8'h80, 32'h0);
    cycles(2);
    bus_wr(8'h8C, 32'd3);
    chk_irq("level_complete_e", 1'b0);
    cycles(1);
    chk_irq("level_complete_e1", 1'b0);
    cycles(1);
    chk_irq("level_complete_e2", 1'b1);
    chk_rd("level_reclaim", 8'h8C, 32'd3);
    src[2] = 1'b0;
    cycles(4);
    bus_wr(8'h8C, 32'd3);
    cycles(4);
    chk_rd("level_quiet", 8'h80, 32'h0);
    chk_irq("level_quiet_irq", 1'b0);
  endtask

  task automatic test_arbitration;
    bus_wr(8'h08, 32'd5);
    bus_wr(8'h18, 32'd5);
    bus_wr(8'h10, 32'd7);
    bus_wr(8'h84, 32'h54);
    src[1] = 1'b1; src[3] = 1'b1; src[5] = 1'b1;
    cycles(5);
    chk_rd("arb_pending", 8'h80, 32'h54);
    chk_rd("arb_claim1", 8'h8C, 32'd4);
    chk_rd("arb_claim2", 8'h8C, 32'd2);
    chk_rd("arb_claim3", 8'h8C, 32'd6);
    chk_rd("arb_claim4", 8'h8C, 32'd0);
    chk_irq("arb_idle", 1'b0);
    src[1] = 1'b0; src[3] = 1'b0; src[5] = 1'b0;
    cycles(4);
    bus_wr(8'h8C, 32'd2);
    bus_wr(8'h8C, 32'd4);
    bus_wr(8'h8C, 32'd6);
    cycles(3);
    chk_rd("arb_done", 8'h80, 32'h0);
  endtask

  task automatic test_threshold;
    bus_wr(8'h88, 32'd5);
    bus_wr(8'h04, 32'd5);
    bus_wr(8'h84, 32'h02);
    src[0] = 1'b1;
    cycles(5);
    chk_irq("thr_blocked", 1'b0);
    chk_rd("thr_pending", 8'h80, 32'h02);
    bus_wr(8'h88, 32'd4);
    chk_irq("thr_e", 1'b0);
    cycles(1);
    chk_irq("thr_e1", 1'b1);
    chk_rd("thr_claim", 8'h8C, 32'd1);
    src[0] = 1'b0;
    cycles(4);
    bus_wr(8'h8C, 32'd1);
    bus_wr(8'h88, 32'd0);
  endtask

  task automatic pulse5;
    src[4] = 1'b1;
    cycles(2);
    src[4] = 1'b0;
    cycles(3);
  endtask

  task automatic test_edge;
    bus_wr(8'h14, 32'd3);
    bus_wr(8'h84, 32'h20);
    pulse5();
    cycles(2);
    chk_irq("edge_irq", 1'b1);
    chk_rd("edge_claim1", 8'h8C, 32'd5);
    pulse5();
    pulse5();
    chk_rd("edge_held_not_pending", 8'h80, 32'h0);
    chk_irq("edge_in_service_irq", 1'b0);
    bus_wr(8'h8C, 32'd5);
    chk_rd("edge_pending_after_complete", 8'h80, 32'h20);
    chk_rd("edge_claim2", 8'h8C, 32'd5);
    chk_rd("edge_claim3", 8'h8C, 32'd0);
    bus_wr(8'h8C, 32'd5);
    cycles(3);
    chk_rd("edge_single_event", 8'h80, 32'h0);
  endtask

  task automatic test_ignore_and_reset;
    bus_wr(8'h0C, 32'd2);
    bus_wr(8'h84, 32'h08);
    src[2] = 1'b1;
    cycles(5);
    bus_wr(8'h8C, 32'd7);
    bus_wr(8'h8C, 32'd0);
    chk_rd("ignore_pending", 8'h80, 32'h08);
    chk_irq("ignore_irq", 1'b1);
    chk_rd("ignore_best", 8'h8C, 32'd3);
    bus_wr(8'h8C, 32'd3);
    cycles(3);
    chk_irq("pre_reset_irq", 1'b1);
    rst = 1'b1; src = '0;
    #1;
    chk_irq("reset_async_irq", 1'b0);
    cycles(2);
    @(negedge clk); rst = 1'b0;
    chk_rd("post_reset_pending", 8'h80, 32'h0);
    chk_rd("post_reset_enable", 8'h84, 32'h0);
    chk_rd("post_reset_prio3", 8'h0C, 32'h0);
    chk_rd("post_reset_claim", 8'h8C, 32'h0);
  endtask

  initial begin
    test_reset();
    test_regs();
    test_level();
    test_arbitration();
    test_threshold();
    test_edge();
    test_ignore_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/plic_lite.md
# plic_lite

Parametrised platform-level interrupt controller feeding the core's external-interrupt line (CSR `irq_external_i` / `mip` external bit). It sits beside the timer/software interrupt sources on the data-memory bus. It gathers `NUM_SRC` asynchronous sources through per-source gateways, each level- or edge-mode. It arbitrates by programmable priority against a threshold and serialises handling through a claim/complete register handshake.

## Interface
- `NUM_SRC`, 8: number of sources, 1..31; source IDs 1..NUM_SRC, ID 0 means "none".
- `PRIO_WIDTH`, 3: priority field width, 1..8.
- `EDGE_MASK`, 0: bit i-1 set means source i is edge-triggered (rising); otherwise level (high).
- `clk_i` in 1: core clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `src_i` in NUM_SRC: raw source lines, asynchronous; bit i-1 is source i.
- `req_i` in 1: bus access strobe, one cycle per access.
- `we_i` in 1: 1 = write, 0 = read.
- `addr_i` in 8: byte offset; bits [1:0] ignored.
- `wdata_i` in 32: write data.
- `rdata_o` out 32: read data, combinational from `addr_i`/state in the `req_i` cycle.
- `irq_o` out 1: registered external interrupt request to the CSR block.

## Operation
- Register map:
  - 0x00+4*i: priority[i], i = 1..NUM_SRC, RW, bits [PRIO_WIDTH-1:0]; offset 0x00 reads 0.
  - 0x80: pending bitmap, RO; bit i = source i.
  - 0x84: enable bitmap, RW; bit i = source i.
  - 0x88: threshold, RW, PRIO_WIDTH bits.
  - 0x8C: claim (read) / complete (write).
  - Unimplemented bits and unmapped offsets read 0; writes to them are ignored.
- Synchroniser: each `src_i` bit passes a 2-flop synchroniser; the gateway sees `s[i]`.
- Level gateway:
  - `pending[i]` sets when `s[i]`=1 and `pending[i]`=0 and `in_service[i]`=0.
  - It never clears on deassert; only a claim clears it.
- Edge gateway:
  - A rising edge of `s[i]` (previous synced value stored) sets `pending[i]` if `pending[i]`=0 and `in_service[i]`=0.
  - If `in_service[i]`=1, the edge sets `edge_held[i]`.
  - An edge while `pending[i]`=1 is coalesced (dropped).
- Eligibility: `pending[i] & enable[i] & (priority[i] > threshold)`. Priority 0 never interrupts.
- Arbitration (registered every cycle into `best_id`):
  - Highest priority among eligible sources; ties go to the lowest ID; none gives 0.
  - The source being claimed in the current cycle is excluded from that cycle's arbitration.
- `irq_o` is registered as (next `best_id` != 0).
- Claim: a read of 0x8C returns `best_id`. At the clock edge, if `best_id` != 0, `pending[best_id]` clears and `in_service[best_id]` sets. A claim with `best_id`=0 has no side effects.
- Complete: a write to 0x8C with `wdata_i[4:0]`=ID in 1..NUM_SRC and `in_service[ID]`=1 clears `in_service[ID]`.
  - Edge source with `edge_held[ID]`=1: `pending[ID]` sets and `edge_held` clears on the same edge.
  - Any other ID, or a non-in-service ID, is ignored.
- Multiple sources may be in service at once (nesting is the software's choice).

## Timing
- Reset (asynchronous, immediate) clears all of the following: priorities, enables, threshold, pending, in_service, edge_held, synchronisers, edge history, `best_id`, and `irq_o`=0. `rdata_o` then reads 0 at every offset.
- Source-to-IRQ latency: `src_i` stable high before edge E1 gives synced at E2, `pending` at E3, and `irq_o`=1 after E4.
- Configuration-to-IRQ latency: an enable/priority/threshold write at edge E makes `irq_o` reflect it after E+1.
- Claim at edge E: `irq_o` and `best_id` reflect the post-claim state after E. There is no stale repeat ID.
- Level source still asserted at complete edge E: `pending` re-sets at E+1 and `irq_o` rises after E+2.
- Same-edge claim and new edge on the claimed edge source: the source becomes in-service and `edge_held` sets.
- Same-edge complete and rising edge on that source: `pending` sets once (single event).
- Reset asserted mid-claim: state clears; the handshake is abandoned.

## Test plan
- Reset, then read all offsets -> 0; `irq_o`=0.
- Source 3 priority 2, enabled, threshold 0, level `src_i[2]` held high -> `irq_o`=1 four edges later. Claim read -> 3; `irq_o`=0 next cycle. Complete 3 with source high -> `irq_o`=1 two edges later.
- Sources 2 (priority 5) and 6 (priority 5) plus 4 (priority 7), all pending -> claims return 4, 2, 6 in order; a fourth claim -> 0.
- Threshold 5, source 1 priority 5 pending -> `irq_o`=0. Write threshold 4 -> `irq_o`=1 one edge later.
- Edge source 5 (`EDGE_MASK`=0x10): claim, then pulse `src_i[4]` twice while in service -> one held event. Complete 5 -> pending=0x20, claim -> 5. A further claim -> 0.
- Complete of a non-in-service ID 7 and of ID 0 -> no state change. Reset asserted while sources are pending -> `irq_o` drops the same cycle.
